dcache_traffic_gen: RTL and testbench

//  Parametrised data-cache stimulus engine; drives the cache CPU-side port with address

---
 rtl/dcache_traffic_gen.sv | 161 ++++++++++++++++
 tb/tb_dcache_traffic_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_traffic_gen.sv
// rtl/dcache_traffic_gen.sv - data-cache CPU-port stimulus engine with write/read sweeps and readback check
// Optional feature: define GEN_STALL_CNT_EN to add the stall_cycles output (posedges spent in WAIT).
module dcache_traffic_gen #(
   parameter int          ADDR_W    = 32,
   parameter int          DATA_W    = 32,
   parameter int          NUM_REQ   = 24,
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned STRIDE    = 4,
   parameter int unsigned DATA_SEED = 1,
   parameter int          ERR_W     = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic              flush,
   input  logic              mem_busy,
   input  logic [DATA_W-1:0] readdata,
   input  logic              readdata_valid,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] writedata,
   output logic              busy,
   output logic              done,
   output logic [ERR_W-1:0]  err_count
`ifdef GEN_STALL_CNT_EN
   ,
   output logic [31:0]       stall_cycles
`endif
);

   localparam int IDX_W = $clog2(NUM_REQ + 1);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REQ);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_WR   = 3'd1;
   localparam logic [2:0] S_RD   = 3'd2;
   localparam logic [2:0] S_WAIT = 3'd3;
   localparam logic [2:0] S_FIN  = 3'd4;

   logic [2:0]        state;
   logic [2:0]        ret_state;
   logic [1:0]        mode_r;
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  ret_cnt;
   logic [ADDR_W-1:0] addr_calc;
   logic [DATA_W-1:0] wdata_calc;
   logic [DATA_W-1:0] rdata_exp;
   logic              rd_phase;

   // Request address/data and expected readback for the current indices; all arithmetic wraps.
   always_comb begin
      addr_calc  = ADDR_W'(BASE_ADDR) + ADDR_W'(idx) * ADDR_W'(STRIDE);
      wdata_calc = DATA_W'(DATA_SEED) + DATA_W'(idx);
      rdata_exp  = DATA_W'(DATA_SEED) + DATA_W'(ret_cnt);
      rd_phase   = (state == S_RD) || ((state == S_WAIT) && (ret_state == S_RD));
   end

   assign busy = (state != S_IDLE);

   // Sequencer: issues one request per free cycle, parks in WAIT while the cache stalls,
   // and counts/check returns independently of the issue index.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= S_IDLE;
         ret_state <= S_IDLE;
         mode_r    <= 2'b00;
         idx       <= '0;
         ret_cnt   <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         address   <= '0;
         writedata <= '0;
         done      <= 1'b0;
         err_count <= '0;
      end else begin
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         done      <= 1'b0;
         if (flush) begin
            state <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     mode_r    <= mode;
                     err_count <= '0;
                     idx       <= '0;
                     ret_cnt   <= '0;
                     state     <= (mode == 2'b00) ? S_RD : S_WR;
                  end
               end
               S_WR: begin
                  if (mem_busy) begin
                     ret_state <= S_WR;
                     state     <= S_WAIT;
                  end else if (idx != LAST) begin
                     mem_write <= 1'b1;
                     address   <= addr_calc;
                     writedata <= wdata_calc;
                     idx       <= idx + 1'b1;
                  end else if (mode_r == 2'b01) begin
                     done  <= 1'b1;
                     state <= S_FIN;
                  end else begin
                     idx   <= '0;
                     state <= S_RD;
                  end
               end
               S_RD: begin
                  if (mem_busy) begin
                     ret_state <= S_RD;
                     state     <= S_WAIT;
                  end else if (idx != LAST) begin
                     mem_read <= 1'b1;
                     address  <= addr_calc;
                     idx      <= idx + 1'b1;
                  end else if (ret_cnt == LAST) begin
                     done  <= 1'b1;
                     state <= S_FIN;
                  end
               end
               // Returning costs one bubble edge: nothing is issued on the edge busy is seen low.
               S_WAIT: begin
                  if (!mem_busy) begin
                     state <= ret_state;
                  end
               end
               S_FIN: begin
                  state <= S_IDLE;
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
            // Returns arrive in issue order, so the k-th one is checked against seed+k.
            if (readdata_valid && rd_phase && (ret_cnt != LAST)) begin
               ret_cnt <= ret_cnt + 1'b1;
               if (mode_r[1] && (readdata != rdata_exp) && (err_count != {ERR_W{1'b1}})) begin
                  err_count <= err_count + 1'b1;
               end
            end
         end
      end
   end

`ifdef GEN_STALL_CNT_EN
   // Stall statistics: posedges spent in WAIT, cleared at run start, saturating.
   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_cycles <= '0;
      end else if ((state == S_IDLE) && start && !flush) begin
         stall_cycles <= '0;
      end else if ((state == S_WAIT) && (stall_cycles != 32'hFFFF_FFFF)) begin
         stall_cycles <= stall_cycles + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_dcache_traffic_gen.sv
// tb/tb_dcache_traffic_gen.sv - directed self-checking bench for dcache_traffic_gen (NUM_REQ=4)
module tb_dcache_traffic_gen;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic        flush = 1'b0;
   logic        mem_busy = 1'b0;
   logic [31:0] readdata = '0;
   logic        readdata_valid = 1'b0;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] address;
   logic [31:0] writedata;
   logic        busy;
   logic        done;
   logic [7:0]  err_count;
`ifdef GEN_STALL_CNT_EN
   logic [31:0] stall_cycles;
`endif

   int vectors = 0;
   int miscompares = 0;

   // memory model state
   logic [31:0] mem [0:15];
   logic        pend_valid = 1'b0;
   logic [31:0] pend_data = '0;
   logic [31:0] corrupt_addr = 32'hFFFF_FFFF;
   int          rd_seen = 0;

   dcache_traffic_gen #(
      .ADDR_W(32), .DATA_W(32), .NUM_REQ(4), .BASE_ADDR(0),
      .STRIDE(4), .DATA_SEED(1), .ERR_W(8)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .flush(flush),
      .mem_busy(mem_busy), .readdata(readdata), .readdata_valid(readdata_valid),
      .mem_read(mem_read), .mem_write(mem_write), .address(address),
      .writedata(writedata), .busy(busy), .done(done), .err_count(err_count)
`ifdef GEN_STALL_CNT_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   // Memory model: stores writes, answers each read one cycle after it is seen.
   always @(posedge clk) begin
      #1;
      readdata_valid = pend_valid;
      readdata       = pend_data;
      pend_valid     = mem_read;
      if (mem_read) begin
         rd_seen   = rd_seen + 1;
         pend_data = (address == corrupt_addr) ? 32'h99 : mem[address[5:2]];
      end
      if (mem_write) mem[address[5:2]] = writedata;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      tick(); tick();
      vectors++; if (mem_read !== 1'b0) begin miscompares++; $display("FAIL reset_mem_read got %0h exp 0", mem_read); end
      vectors++; if (mem_write !== 1'b0) begin miscompares++; $display("FAIL reset_mem_write got %0h exp 0", mem_write); end
      vectors++; if (address !== 32'h0) begin miscompares++; $display("FAIL reset_address got %0h exp 0", address); end
      vectors++; if (writedata !== 32'h0) begin miscompares++; $display("FAIL reset_writedata got %0h exp 0", writedata); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0h exp 0", busy); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %0h exp 0", done); end
      vectors++; if (err_count !== 8'h0) begin miscompares++; $display("FAIL reset_err got %0h exp 0", err_count); end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_write_sweep;
      mode = 2'b01; start = 1'b1;
      tick();
      start = 1'b0;
      vectors++; if ({busy, mem_write} !== 2'b10) begin miscompares++; $display("FAIL wr_first_latency got busy,wr=%b exp 10", {busy, mem_write}); end
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if ({mem_write, address, writedata} !== {1'b1, 32'(4 * i), 32'(1 + i)}) begin
            miscompares++;
            $display("FAIL wr_req%0d got wr=%0h addr=%0h data=%0h exp 1/%0h/%0h", i, mem_write, address, writedata, 4 * i, 1 + i);
         end
      end
      tick();
      vectors++; if ({done, mem_write, busy} !== 3'b101) begin miscompares++; $display("FAIL wr_done got done,wr,busy=%b exp 101", {done, mem_write, busy}); end
      tick();
      vectors++; if ({done, busy} !== 2'b00) begin miscompares++; $display("FAIL wr_idle got done,busy=%b exp 00", {done, busy}); end
   endtask

   task automatic test_read_stall;
      int base;
      base = rd_seen;
      mode = 2'b00; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      vectors++; if ({mem_read, address} !== {1'b1, 32'h0}) begin miscompares++; $display("FAIL rd_req0 got rd=%0h addr=%0h exp 1/0", mem_read, address); end
      tick();
      vectors++; if ({mem_read, address} !== {1'b1, 32'h4}) begin miscompares++; $display("FAIL rd_req1 got rd=%0h addr=%0h exp 1/4", mem_read, address); end
      mem_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) mem_busy = 1'b0;
         tick();
         vectors++; if (mem_read !== 1'b0) begin miscompares++; $display("FAIL rd_stall%0d got rd=%0h exp 0", i, mem_read); end
      end
      tick();
      vectors++; if ({mem_read, address} !== {1'b1, 32'h8}) begin miscompares++; $display("FAIL rd_req2 got rd=%0h addr=%0h exp 1/8", mem_read, address); end
      tick();
      vectors++; if ({mem_read, address} !== {1'b1, 32'hC}) begin miscompares++; $display("FAIL rd_req3 got rd=%0h addr=%0h exp 1/c", mem_read, address); end
      tick(); tick();
      vectors++; if ({mem_read, done} !== 2'b00) begin miscompares++; $display("FAIL rd_tail got rd,done=%b exp 00", {mem_read, done}); end
      tick();
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL rd_done got %0h exp 1", done); end
      tick();
      vectors++; if (rd_seen - base !== 4) begin miscompares++; $display("FAIL rd_count got %0d exp 4", rd_seen - base); end
`ifdef GEN_STALL_CNT_EN
      vectors++; if (stall_cycles !== 32'd3) begin miscompares++; $display("FAIL stall_cycles got %0d exp 3", stall_cycles); end
`endif
   endtask

   task automatic test_readback(input logic [31:0] bad_addr, input logic [7:0] exp_err, input string tag);
      int waited;
      corrupt_addr = bad_addr;
      mode = 2'b10; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++; if ({mem_write, address, writedata} !== {1'b1, 32'(4 * i), 32'(1 + i)}) begin
            miscompares++; $display("FAIL %s_wr%0d got wr=%0h addr=%0h data=%0h", tag, i, mem_write, address, writedata);
         end
      end
      tick();
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++; if ({mem_read, address} !== {1'b1, 32'(4 * i)}) begin
            miscompares++; $display("FAIL %s_rd%0d got rd=%0h addr=%0h exp 1/%0h", tag, i, mem_read, address, 4 * i);
         end
      end
      waited = 0;
      while (done !== 1'b1 && waited < 12) begin tick(); waited++; end
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL %s_done_timeout got done=%0h exp 1", tag, done); end
      vectors++; if (err_count !== exp_err) begin miscompares++; $display("FAIL %s_err got %0d exp %0d", tag, err_count, exp_err); end
      tick();
      corrupt_addr = 32'hFFFF_FFFF;
   endtask

   task automatic test_flush;
      int waited;
      mode = 2'b01; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      vectors++; if ({busy, mem_write, done} !== 3'b000) begin miscompares++; $display("FAIL flush_idle got busy,wr,done=%b exp 000", {busy, mem_write, done}); end
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++; if ({done, mem_write} !== 2'b00) begin miscompares++; $display("FAIL flush_quiet%0d got done,wr=%b exp 00", i, {done, mem_write}); end
      end
      start = 1'b1; flush = 1'b1;
      tick();
      start = 1'b0; flush = 1'b0;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL flush_beats_start got busy=%0h exp 0", busy); end
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      vectors++; if ({mem_write, address, writedata} !== {1'b1, 32'h0, 32'h1}) begin
         miscompares++; $display("FAIL flush_restart got wr=%0h addr=%0h data=%0h exp 1/0/1", mem_write, address, writedata);
      end
      waited = 0;
      while (done !== 1'b1 && waited < 10) begin tick(); waited++; end
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL flush_rerun_done got %0h exp 1", done); end
      tick();
   endtask

   task automatic test_reset_mid_run;
      mode = 2'b00; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      vectors++; if ({mem_read, mem_write, busy, done} !== 4'b0000 || address !== 32'h0 || err_count !== 8'h0) begin
         miscompares++; $display("FAIL reset_mid got rd,wr,busy,done=%b addr=%0h err=%0h exp 0", {mem_read, mem_write, busy, done}, address, err_count);
      end
`ifdef GEN_STALL_CNT_EN
      vectors++; if (stall_cycles !== 32'd0) begin miscompares++; $display("FAIL reset_mid_stall got %0d exp 0", stall_cycles); end
`endif
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++; if ({busy, done} !== 2'b00) begin miscompares++; $display("FAIL reset_mid_quiet%0d got busy,done=%b exp 00", i, {busy, done}); end
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = '0;
      test_reset();
      test_write_sweep();
      test_read_stall();
      test_readback(32'hFFFF_FFFF, 8'd0, "rb_echo");
      test_readback(32'h4, 8'd1, "rb_corrupt");
      test_flush();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
